instruction_fetch_queue: RTL

- Fetch stage that sits directly upstream of the single-cycle execution datapath.
- Issues word reads to instruction memory over a req/ack handshake, one outstanding request at a time.
- Buffers returned words with their PCs in a small FIFO and presents them downstream with valid/ready.
- Flushes and restarts at a new PC on redirect (taken branch, j, jal, jr).

---
 rtl/instruction_fetch_queue_pkg.sv | 23 ++
 rtl/ifq_fifo.sv | 59 +++++
 rtl/instruction_fetch_queue.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Fetch FSM states, the FIFO entry layout and a PC alignment helper.
package instruction_fetch_queue_pkg;

  localparam int          INSTR_WIDTH  = 32;
  localparam logic [31:0] PC_INCREMENT = 32'd4;

  typedef enum logic [1:0] {
    IFQ_IDLE  = 2'd0,
    IFQ_REQ   = 2'd1,
    IFQ_DRAIN = 2'd2
  } ifq_state_t;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] word;
    logic [31:0]            pc;
  } ifq_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] pc);
    return pc & ~32'h3;
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// DEPTH x 64-bit FIFO of {instruction word, PC} for the fetch queue.
// Ports: push/wdata, pop/rdata, flush, full, empty, count.
module ifq_fifo
  import instruction_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  ifq_entry_t             wdata,
  output ifq_entry_t             rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  ifq_entry_t  mem [DEPTH];
  ifq_entry_t  last_q;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        push_ok;
  logic        pop_ok;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  // When empty the head shows whatever it showed last cycle.
  assign rdata = empty ? last_q : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_q <= '0;
    end else begin
      last_q <= rdata;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch stage: one-outstanding word reads, FIFO of {word, PC}, redirect.
// Ports: clk, reset, redirect/redirect_pc, mem_req/addr/ack/rdata,
//   instr_valid/instr/instr_pc/instr_ready.
// Option IFQ_PERF_COUNTERS_EN adds perf_fetched/perf_squashed/perf_stall.
module instruction_fetch_queue
  import instruction_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic                   mem_req,
  output logic [31:0]            mem_addr,
  input  logic                   mem_ack,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [31:0]            instr_pc,
  input  logic                   instr_ready
`ifdef IFQ_PERF_COUNTERS_EN
  ,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_squashed,
  output logic [31:0]            perf_stall
`endif
);

  localparam int AW = $clog2(DEPTH);

  ifq_state_t  state;
  logic [31:0] fetch_pc;
  logic [31:0] pc_next;
  logic [31:0] rpc;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic        room;
  logic [AW:0] count;
  logic [AW+1:0] cnt_after;
  ifq_entry_t  wdata;
  ifq_entry_t  head;

  assign rpc     = word_align(redirect_pc);
  assign pc_next = fetch_pc + PC_INCREMENT;

  assign push = mem_ack && (state == IFQ_REQ) && !redirect;
  assign pop  = instr_valid && instr_ready && !redirect;

  // Occupancy after this cycle's push/pop decides whether to keep going.
  assign cnt_after = {1'b0, count} + (AW+2)'(1) - (AW+2)'(pop);
  assign room      = cnt_after < (AW+2)'(DEPTH);

  assign wdata.word = mem_rdata;
  assign wdata.pc   = fetch_pc;

  assign instr_valid = !empty;
  assign instr       = head.word;
  assign instr_pc    = head.pc;

  ifq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .flush(redirect),
    .wdata(wdata),
    .rdata(head),
    .full (full),
    .empty(empty),
    .count(count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IFQ_IDLE;
      fetch_pc <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
    end else begin
      case (state)
        IFQ_IDLE: begin
          if (redirect) begin
            fetch_pc <= rpc;
            state    <= IFQ_REQ;
            mem_req  <= 1'b1;
            mem_addr <= rpc;
          end else if (!full) begin
            state    <= IFQ_REQ;
            mem_req  <= 1'b1;
            mem_addr <= fetch_pc;
          end
        end
        IFQ_REQ: begin
          if (redirect) begin
            fetch_pc <= rpc;
            if (mem_ack) mem_addr <= rpc;
            else state <= IFQ_DRAIN;
          end else if (mem_ack) begin
            fetch_pc <= pc_next;
            if (room) begin
              mem_addr <= pc_next;
            end else begin
              state   <= IFQ_IDLE;
              mem_req <= 1'b0;
            end
          end
        end
        IFQ_DRAIN: begin
          // Old request must complete on the bus; its data is dropped.
          if (redirect) fetch_pc <= rpc;
          if (mem_ack) begin
            state    <= IFQ_REQ;
            mem_addr <= redirect ? rpc : fetch_pc;
          end
        end
        default: begin
          state   <= IFQ_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef IFQ_PERF_COUNTERS_EN
  logic squash;
  assign squash = mem_ack &&
    (((state == IFQ_REQ) && redirect) || (state == IFQ_DRAIN));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
      perf_stall    <= '0;
    end else begin
      if (push && (perf_fetched != '1))
        perf_fetched <= perf_fetched + 1'b1;
      if (squash && (perf_squashed != '1))
        perf_squashed <= perf_squashed + 1'b1;
      if (instr_ready && !instr_valid && (perf_stall != '1))
        perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule
